move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
- Sequences every piece action during gameplay.
- Takes keyboard move requests and the difficulty gravity tick, and serialises them into one command at a time to the board collision-check datapath over a valid/ready + response handshake.
- Issues commit, lock and spawn events.
- Sits between the keyboard decode / gameplay FSM and the board datapath.

Parameters:
- LOCK_DELAY, 2: consecutive failed down moves (gravity or soft) before the piece locks; legal range 1..15.
- RSP_TIMEOUT, 255: cycles allowed in WAIT_RSP before the response is forced to fail; 8-bit counter.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  gameplay mode active; level
- grav_tick  in  1  one-cycle gravity pulse at the selected difficulty rate
- key_left, key_right, key_down, key_rotate  in  1 each  decoded key levels; the block edge-detects them
- cmd_valid  out  1  command offered to checker
- cmd_op  out  3  0=LEFT 1=RIGHT 2=ROT 3=SOFT_DOWN 4=GRAV_DOWN 5=SPAWN
- cmd_ready  in  1  checker accepts command
- rsp_valid  in  1  checker result strobe
- rsp_ok  in  1  1=move legal
- commit  out  1  one-cycle pulse: apply commit_op to the active piece
- commit_op  out  3  op being committed
- lock  out  1  one-cycle pulse: freeze piece into board
- game_over  out  1  level; spawn blocked
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; a response timed out

Behaviour:
- Reset: all outputs 0. State IDLE. Pending bits 0, lock_cnt 0, edge-detect registers 0, err_timeout 0.
- Edge detect: a key is 1 this cycle and 0 last cycle, or grav_tick=1, -> set the matching pending bit (P_GRAV, P_ROT, P_DOWN, P_LEFT, P_RIGHT) at the next clock.
  - Repeated edges while a bit is pending merge into one request.
- Pending capture: bits are captured only while enable=1 and state is not OVER or SPAWN_*.
- Priority: GRAV > ROT > SOFT_DOWN > LEFT > RIGHT. Simultaneous left+right requests are both served, left first.
- States:
  - IDLE: any pending -> ISSUE with the highest-priority op; clear that bit on entry. If a new edge for the same bit arrives in that cycle, set wins and the bit stays pending.
  - ISSUE: cmd_valid=1, cmd_op stable until cmd_ready=1 is sampled. On that cycle -> WAIT_RSP and reset the timeout counter.
  - WAIT_RSP: wait for rsp_valid. rsp_valid is ignored in the ISSUE transfer cycle and in every other state.
    - Success: rsp_ok=1 -> COMMIT.
    - Failure: rsp_ok=0, or counter reaches RSP_TIMEOUT -> FAIL. On timeout also set err_timeout.
  - COMMIT: commit=1, commit_op=op for exactly one cycle. If op is SOFT_DOWN or GRAV_DOWN, lock_cnt<=0. Then -> IDLE.
  - FAIL: non-down op -> IDLE, no commit. Down op -> lock_cnt+1; if the new value equals LOCK_DELAY -> LOCK, else -> IDLE.
  - LOCK: lock=1 for one cycle. lock_cnt<=0, all pending bits cleared -> SPAWN_ISSUE.
  - SPAWN_ISSUE / SPAWN_WAIT: same handshake as ISSUE / WAIT_RSP with cmd_op=5.
    - ok -> commit pulse with commit_op=5 -> IDLE.
    - fail or timeout -> OVER.
  - OVER: game_over=1. No commands issued. Held until reset or enable falls.
- Enable rise (0->1): from IDLE, go directly to SPAWN_ISSUE (first piece).
- Enable fall: next clock -> IDLE. cmd_valid drops immediately (abort). Pending bits, lock_cnt and game_over cleared. Any in-flight response is discarded.
- Latency (checker always ready, response 1 cycle after transfer):
  - key edge sampled at cycle N, pending at N+1, cmd_valid at N+2, transfer at N+2, rsp at N+3, commit at N+4.
  - IDLE->ISSUE re-arbitration costs 1 cycle, so back-to-back throughput is 1 command per 4 cycles.
- Only one command is ever outstanding; cmd_valid never asserts outside ISSUE/SPAWN_ISSUE.
- reset overrides enable in the same cycle.

Test Plan:
- Reset, then enable=1, checker ok/1-cycle -> SPAWN command (op 5) transferred, commit with commit_op=5 exactly 4 cycles after enable rise, then busy=0.
- key_left and key_right rise in the same cycle together with grav_tick -> commands issued in order 4, 0, 1; three commit pulses; no request dropped.
- LOCK_DELAY=2: two grav_ticks answered rsp_ok=0 -> no commit, one lock pulse after the second failure, then SPAWN issued; pending bits empty afterwards.
- Gravity fail, then soft-down success, then gravity fail -> no lock (lock_cnt reset by the success).
- Checker never raises rsp_valid -> after 255 WAIT_RSP cycles FAIL taken, err_timeout=1 and stays 1 until reset.
- SPAWN answered rsp_ok=0 -> game_over=1; held key edges cause no cmd_valid; enable dropped -> game_over=0 and busy=0 next cycle.

Source files
------------

// File: rtl/move_scheduler_if.sv
`default_nettype none
// ============================================================================
// move_scheduler_if : command / response handshake to the board collision checker
// Rev 1.0
// ============================================================================
interface move_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_ok;

  modport master (
    output cmd_valid,
    output cmd_op,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_ok
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    output cmd_ready,
    output rsp_valid,
    output rsp_ok
  );
endinterface
`default_nettype wire

// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// move_scheduler : serialises key moves, gravity and spawns onto the board checker
// Rev 1.0
// ============================================================================
module move_scheduler #(
  parameter int LOCK_DELAY  = 2,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             grav_tick,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_down,
  input  logic             key_rotate,
  move_scheduler_if.master chk,
  output logic             commit,
  output logic [2:0]       commit_op,
  output logic             lock,
  output logic             game_over,
  output logic             busy,
  output logic             err_timeout
);

  localparam logic [2:0] c_OP_LEFT  = 3'd0;
  localparam logic [2:0] c_OP_RIGHT = 3'd1;
  localparam logic [2:0] c_OP_ROT   = 3'd2;
  localparam logic [2:0] c_OP_SOFT  = 3'd3;
  localparam logic [2:0] c_OP_GRAV  = 3'd4;
  localparam logic [2:0] c_OP_SPAWN = 3'd5;

  localparam int c_P_GRAV  = 0;
  localparam int c_P_ROT   = 1;
  localparam int c_P_DOWN  = 2;
  localparam int c_P_LEFT  = 3;
  localparam int c_P_RIGHT = 4;

  localparam logic [3:0] c_LOCK_DELAY  = 4'(LOCK_DELAY);
  localparam logic [7:0] c_RSP_TIMEOUT = 8'(RSP_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_ISSUE       = 4'd1,
    S_WAIT_RSP    = 4'd2,
    S_COMMIT      = 4'd3,
    S_FAIL        = 4'd4,
    S_LOCK        = 4'd5,
    S_SPAWN_ISSUE = 4'd6,
    S_SPAWN_WAIT  = 4'd7,
    S_OVER        = 4'd8
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_key_d;
  logic       r_en_d;
  logic [4:0] r_pend;
  logic       r_spawn_req;
  logic [2:0] r_op, w_op_nxt;
  logic [3:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [7:0] r_to_cnt, w_to_cnt_nxt;
  logic       r_err;

  logic [3:0] w_keys;
  logic [4:0] w_edge;
  logic [4:0] w_pend_clr;
  logic       w_pend_flush, w_spawn_take, w_err_set;
  logic       w_capture, w_en_rise, w_cmd_valid, w_xfer, w_is_down;
  logic [3:0] w_lock_inc;
  logic [7:0] w_to_inc;

  // Key bits line up with pending bits ROT..RIGHT; gravity is already a pulse.
  assign w_keys     = {key_right, key_left, key_down, key_rotate};
  assign w_edge     = {w_keys & ~r_key_d, grav_tick};
  assign w_en_rise  = enable & ~r_en_d;
  assign w_capture  = enable && (r_state != S_OVER) &&
                      (r_state != S_SPAWN_ISSUE) && (r_state != S_SPAWN_WAIT);
  assign w_cmd_valid = enable && ((r_state == S_ISSUE) || (r_state == S_SPAWN_ISSUE));
  assign w_xfer     = w_cmd_valid && chk.cmd_ready;
  assign w_is_down  = (r_op == c_OP_SOFT) || (r_op == c_OP_GRAV);
  assign w_lock_inc = r_lock_cnt + 4'd1;
  assign w_to_inc   = r_to_cnt + 8'd1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_pend_clr     = '0;
    w_pend_flush   = 1'b0;
    w_spawn_take   = 1'b0;
    w_lock_cnt_nxt = r_lock_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_err_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_spawn_req) begin
          w_state_nxt  = S_SPAWN_ISSUE;
          w_op_nxt     = c_OP_SPAWN;
          w_spawn_take = 1'b1;
        end else if (r_pend[c_P_GRAV]) begin
          w_state_nxt = S_ISSUE; w_op_nxt = c_OP_GRAV;  w_pend_clr[c_P_GRAV]  = 1'b1;
        end else if (r_pend[c_P_ROT]) begin
          w_state_nxt = S_ISSUE; w_op_nxt = c_OP_ROT;   w_pend_clr[c_P_ROT]   = 1'b1;
        end else if (r_pend[c_P_DOWN]) begin
          w_state_nxt = S_ISSUE; w_op_nxt = c_OP_SOFT;  w_pend_clr[c_P_DOWN]  = 1'b1;
        end else if (r_pend[c_P_LEFT]) begin
          w_state_nxt = S_ISSUE; w_op_nxt = c_OP_LEFT;  w_pend_clr[c_P_LEFT]  = 1'b1;
        end else if (r_pend[c_P_RIGHT]) begin
          w_state_nxt = S_ISSUE; w_op_nxt = c_OP_RIGHT; w_pend_clr[c_P_RIGHT] = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_xfer) begin
          w_state_nxt  = S_WAIT_RSP;
          w_to_cnt_nxt = '0;
        end
      end
      S_WAIT_RSP: begin
        w_to_cnt_nxt = w_to_inc;
        if (chk.rsp_valid) begin
          w_state_nxt = chk.rsp_ok ? S_COMMIT : S_FAIL;
        end else if (w_to_inc == c_RSP_TIMEOUT) begin
          w_state_nxt = S_FAIL;
          w_err_set   = 1'b1;
        end
      end
      S_COMMIT: begin
        if (w_is_down) w_lock_cnt_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      S_FAIL: begin
        w_state_nxt = S_IDLE;
        if (w_is_down) begin
          w_lock_cnt_nxt = w_lock_inc;
          if (w_lock_inc == c_LOCK_DELAY) w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        w_lock_cnt_nxt = '0;
        w_pend_flush   = 1'b1;
        w_state_nxt    = S_SPAWN_ISSUE;
        w_op_nxt       = c_OP_SPAWN;
      end
      S_SPAWN_ISSUE: begin
        if (w_xfer) begin
          w_state_nxt  = S_SPAWN_WAIT;
          w_to_cnt_nxt = '0;
        end
      end
      S_SPAWN_WAIT: begin
        w_to_cnt_nxt = w_to_inc;
        if (chk.rsp_valid) begin
          w_state_nxt = chk.rsp_ok ? S_COMMIT : S_OVER;
        end else if (w_to_inc == c_RSP_TIMEOUT) begin
          w_state_nxt = S_OVER;
          w_err_set   = 1'b1;
        end
      end
      S_OVER: w_state_nxt = S_OVER;
      default: w_state_nxt = S_IDLE;
    endcase
    // Leaving gameplay aborts everything, including any response still in flight.
    if (!enable) begin
      w_state_nxt    = S_IDLE;
      w_pend_flush   = 1'b1;
      w_lock_cnt_nxt = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_key_d     <= '0;
      r_en_d      <= 1'b0;
      r_pend      <= '0;
      r_spawn_req <= 1'b0;
      r_op        <= '0;
      r_lock_cnt  <= '0;
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_key_d <= w_keys;
      r_en_d  <= enable;
      // A fresh edge beats the clear of the bit being issued, so it is not lost.
      r_pend  <= w_pend_flush ? 5'd0 : ((r_pend & ~w_pend_clr) | (w_capture ? w_edge : 5'd0));
      if (!enable)           r_spawn_req <= 1'b0;
      else if (w_en_rise)    r_spawn_req <= 1'b1;
      else if (w_spawn_take) r_spawn_req <= 1'b0;
      r_op       <= w_op_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign chk.cmd_valid = w_cmd_valid;
  assign chk.cmd_op    = r_op;
  assign commit        = (r_state == S_COMMIT);
  assign commit_op     = commit ? r_op : 3'd0;
  assign lock          = (r_state == S_LOCK);
  assign game_over     = (r_state == S_OVER);
  assign busy          = (r_state != S_IDLE);
  assign err_timeout   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// ============================================================================
// tb_move_scheduler : directed self-checking bench with a 1-cycle checker model
// Rev 1.0
// ============================================================================
module tb_move_scheduler;
  logic       CLOCK_50   = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b0;
  logic       grav_tick  = 1'b0;
  logic       key_left   = 1'b0;
  logic       key_right  = 1'b0;
  logic       key_down   = 1'b0;
  logic       key_rotate = 1'b0;
  logic       commit, lock, game_over, busy, err_timeout;
  logic [2:0] commit_op;

  move_scheduler_if chk();

  int         checks = 0;
  int         errors = 0;
  logic       rsp_on = 1'b1;
  logic       ok_q[$];
  logic [2:0] xfer_log[$];
  logic [2:0] commit_log[$];
  int         lock_seen = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  move_scheduler #(.LOCK_DELAY(2), .RSP_TIMEOUT(255)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enable     (enable),
    .grav_tick  (grav_tick),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .chk        (chk),
    .commit     (commit),
    .commit_op  (commit_op),
    .lock       (lock),
    .game_over  (game_over),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  // Checker model: answers one cycle after each transfer, ok taken from ok_q (default ok).
  initial begin : checker_model
    logic hit;
    chk.rsp_valid = 1'b0;
    chk.rsp_ok    = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      hit = chk.cmd_valid && chk.cmd_ready;
      if (hit) xfer_log.push_back(chk.cmd_op);
      if (commit) commit_log.push_back(commit_op);
      if (lock) lock_seen++;
      @(posedge CLOCK_50);
      #1;
      chk.rsp_valid = hit && rsp_on;
      chk.rsp_ok    = 1'b0;
      if (hit && rsp_on) chk.rsp_ok = (ok_q.size() > 0) ? ok_q.pop_front() : 1'b1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic string q2s(input logic [2:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic bit q_same(input logic [2:0] a[$], input logic [2:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic clear_logs();
    xfer_log.delete();
    commit_log.delete();
    lock_seen = 0;
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1; enable = 1'b0; grav_tick = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_down = 1'b0; key_rotate = 1'b0;
    rsp_on = 1'b1; chk.cmd_ready = 1'b1;
    ok_q.delete();
    step(2);
    reset = 1'b0;
    step(1);
    clear_logs();
  endtask

  task automatic start_game();
    do_reset();
    enable = 1'b1;
    step(8);
    clear_logs();
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    chk.cmd_ready = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1; enable = 1'b1; key_left = 1'b1; grav_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      outs = {chk.cmd_valid, chk.cmd_op, commit, commit_op, lock, game_over, busy, err_timeout};
      checks++;
      if (outs !== 12'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected 000000000000", k, outs);
      end
    end
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0; enable = 1'b0; key_left = 1'b0; grav_tick = 1'b0;
    step(4);
    checks++;
    if (busy !== 1'b0 || xfer_log.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b transfers=%0d expected busy=0 transfers=0", busy, xfer_log.size());
    end
  endtask

  task automatic test_spawn();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLOCK_50);
      checks++;
      if (commit !== (k == 4)) begin
        errors++;
        $display("FAIL spawn_commit_time[%0d]: got %b expected %b", k, commit, (k == 4));
      end
      if (k == 2) begin
        checks++;
        if ({chk.cmd_valid, chk.cmd_op} !== {1'b1, 3'd5}) begin
          errors++;
          $display("FAIL spawn_cmd: got valid=%b op=%0d expected valid=1 op=5", chk.cmd_valid, chk.cmd_op);
        end
      end
      if (k == 4) begin
        checks++;
        if (commit_op !== 3'd5) begin
          errors++;
          $display("FAIL spawn_commit_op: got %0d expected 5", commit_op);
        end
      end
      if (k == 6) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL spawn_busy_after: got %b expected 0", busy);
        end
      end
    end
    step(1);
  endtask

  task automatic test_priority();
    logic       exp_c;
    logic [2:0] exp_op;
    logic [2:0] exp_q[$];
    start_game();
    key_left = 1'b1; key_right = 1'b1; grav_tick = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLOCK_50);
      exp_c  = (k == 4) || (k == 8) || (k == 12);
      exp_op = (k == 4) ? 3'd4 : (k == 8) ? 3'd0 : (k == 12) ? 3'd1 : 3'd0;
      checks++;
      if (commit !== exp_c || commit_op !== exp_op) begin
        errors++;
        $display("FAIL priority_commit[%0d]: got commit=%b op=%0d expected commit=%b op=%0d",
                 k, commit, commit_op, exp_c, exp_op);
      end
      if (k == 0) begin
        @(posedge CLOCK_50);
        #1;
        grav_tick = 1'b0;
      end
    end
    step(2);
    key_left = 1'b0; key_right = 1'b0;
    step(2);
    exp_q = '{3'd4, 3'd0, 3'd1};
    checks++;
    if (!q_same(xfer_log, exp_q)) begin
      errors++;
      $display("FAIL priority_order: got %s expected 4 0 1", q2s(xfer_log));
    end
  endtask

  task automatic test_lock();
    logic [2:0] exp_x[$];
    logic [2:0] exp_c[$];
    start_game();
    ok_q.push_back(1'b0);
    ok_q.push_back(1'b0);
    grav_tick = 1'b1; step(1); grav_tick = 1'b0;
    step(7);
    grav_tick = 1'b1; step(1); grav_tick = 1'b0;
    step(2);
    key_left = 1'b1;       // lands in pending just before the lock flush
    step(20);
    key_left = 1'b0;
    step(2);
    exp_x = '{3'd4, 3'd4, 3'd5};
    exp_c = '{3'd5};
    checks++;
    if (lock_seen != 1) begin
      errors++;
      $display("FAIL lock_pulses: got %0d expected 1", lock_seen);
    end
    checks++;
    if (!q_same(xfer_log, exp_x)) begin
      errors++;
      $display("FAIL lock_transfers: got %s expected 4 4 5", q2s(xfer_log));
    end
    checks++;
    if (!q_same(commit_log, exp_c)) begin
      errors++;
      $display("FAIL lock_commits: got %s expected 5", q2s(commit_log));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle_after: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_lock_reset();
    logic [2:0] exp_x[$];
    start_game();
    ok_q = '{1'b0, 1'b1, 1'b0, 1'b0};
    grav_tick = 1'b1; step(1); grav_tick = 1'b0;
    step(8);
    key_down = 1'b1;
    step(10);
    key_down = 1'b0;
    step(1);
    grav_tick = 1'b1; step(1); grav_tick = 1'b0;
    step(10);
    checks++;
    if (lock_seen != 0) begin
      errors++;
      $display("FAIL lockcnt_reset_no_lock: got %0d lock pulses expected 0", lock_seen);
    end
    exp_x = '{3'd4, 3'd3, 3'd4};
    checks++;
    if (!q_same(xfer_log, exp_x)) begin
      errors++;
      $display("FAIL lockcnt_reset_order: got %s expected 4 3 4", q2s(xfer_log));
    end
    checks++;
    if (commit_log.size() != 1 || commit_log[0] !== 3'd3) begin
      errors++;
      $display("FAIL lockcnt_reset_commit: got %s expected 3", q2s(commit_log));
    end
    grav_tick = 1'b1; step(1); grav_tick = 1'b0;
    step(15);
    checks++;
    if (lock_seen != 1) begin
      errors++;
      $display("FAIL lockcnt_second_fail_locks: got %0d lock pulses expected 1", lock_seen);
    end
  endtask

  task automatic test_timeout();
    start_game();
    rsp_on = 1'b0;
    grav_tick = 1'b1;
    for (int k = 0; k <= 258; k++) begin
      @(negedge CLOCK_50);
      if (k == 257) begin
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL timeout_early: got err=%b busy=%b expected err=0 busy=1", err_timeout, busy);
        end
      end
      if (k == 258) begin
        checks++;
        if (err_timeout !== 1'b1) begin
          errors++;
          $display("FAIL timeout_flag: got %b expected 1", err_timeout);
        end
      end
      if (k == 0) begin
        @(posedge CLOCK_50);
        #1;
        grav_tick = 1'b0;
      end
    end
    step(1);
    rsp_on = 1'b1;
    step(5);
    checks++;
    if (err_timeout !== 1'b1 || commit_log.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got err=%b commits=%0d busy=%b expected err=1 commits=0 busy=0",
               err_timeout, commit_log.size(), busy);
    end
    enable = 1'b0;
    step(3);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
    end
    do_reset();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cleared_by_reset: got %b expected 0", err_timeout);
    end
  endtask

  task automatic test_game_over();
    logic saw_valid;
    do_reset();
    ok_q.push_back(1'b0);
    enable = 1'b1;
    step(7);
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL over_entered: got game_over=%b busy=%b expected 1 1", game_over, busy);
    end
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      key_left   = k[1];
      key_rotate = k[0];
      grav_tick  = (k == 3);
      @(negedge CLOCK_50);
      if (chk.cmd_valid) saw_valid = 1'b1;
      @(posedge CLOCK_50);
      #1;
    end
    key_left = 1'b0; key_rotate = 1'b0; grav_tick = 1'b0;
    checks++;
    if (saw_valid !== 1'b0 || xfer_log.size() != 1) begin
      errors++;
      $display("FAIL over_no_commands: got saw_valid=%b transfers=%0d expected 0 1", saw_valid, xfer_log.size());
    end
    enable = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_held_until_edge: got %b expected 1", game_over);
    end
    @(negedge CLOCK_50);
    checks++;
    if (game_over !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL over_cleared: got game_over=%b busy=%b expected 0 0", game_over, busy);
    end
    step(1);
  endtask

  task automatic test_abort();
    logic [2:0] exp_q[$];
    start_game();
    chk.cmd_ready = 1'b0;
    grav_tick = 1'b1; step(1); grav_tick = 1'b0;
    step(1);
    @(negedge CLOCK_50);
    checks++;
    if ({chk.cmd_valid, chk.cmd_op} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL abort_offer: got valid=%b op=%0d expected valid=1 op=4", chk.cmd_valid, chk.cmd_op);
    end
    @(posedge CLOCK_50);
    #1;
    enable = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (chk.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_valid_drop: got %b expected 0", chk.cmd_valid);
    end
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b expected 0", busy);
    end
    @(posedge CLOCK_50);
    #1;
    chk.cmd_ready = 1'b1;
    enable = 1'b1;
    clear_logs();
    step(10);
    exp_q = '{3'd5};
    checks++;
    if (!q_same(xfer_log, exp_q) || !q_same(commit_log, exp_q)) begin
      errors++;
      $display("FAIL abort_restart: got transfers %s commits %s expected 5 and 5",
               q2s(xfer_log), q2s(commit_log));
    end
  endtask

  initial begin : main
    chk.cmd_ready = 1'b1;
    test_reset();
    test_spawn();
    test_priority();
    test_lock();
    test_lock_reset();
    test_timeout();
    test_game_over();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
